pc_unit: RTL and testbench

- Program-counter stage that sits directly downstream of the control FSM. It consumes the FSM's pc_en/pc_ld strobes and drives the instruction-memory address (port A address when pc_sel=1).
- Supports sequential increment, absolute register jump, PC-relative displacement branch, jump-and-link, and an optional return-address stack (RAS).
- All state updates on posedge clk; no combinational path from inputs to pc_out.

---
 rtl/pc_unit.sv | 171 +++++++++++++++++
 tb/tb_pc_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage fed by the control FSM's pc_en/pc_ld strobes.
// Handles increment, absolute jump, PC-relative branch, jump-and-link and
// (when the PC_RAS_EN macro is defined) a circular return-address stack.
// Without PC_RAS_EN no stack storage is built: ret is ignored, ras_empty
// reads 1 and ras_full/ras_err read 0.
// Handshake: there is no valid/ready pair; pc_en is a one-cycle strobe and
// every strobed operation completes in that cycle, result visible next cycle.
module pc_unit #(
    parameter int                 ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic              pc_ld,
    input  logic              rel,
    input  logic [ADDR_W-1:0] tgt_reg,
    input  logic [7:0]        disp,
    input  logic              link,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] link_out,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_err
);

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_INC,
        PH_LOAD_ABS,
        PH_LOAD_REL,
        PH_LOAD_RET
    } phase_e;

    phase_e            phase;
    logic              take_ret;
    logic              ras_hit;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] disp_ext;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] link_q, link_d;

    assign disp_ext = {{(ADDR_W-8){disp[7]}}, disp};

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d, top_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              push, pop;

    assign take_ret = ret;
    assign ras_hit  = (cnt_q != '0);
    assign ras_top  = ras_q[top_q];
    assign top_inc  = top_q + PTR_W'(1);
    assign push     = pc_en & pc_ld & link;
    assign pop      = (phase == PH_LOAD_RET);

    // Stack update: pop, replace-top (link+ret), or circular push; flags follow next count.
    always_comb begin
        ras_d   = ras_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (pop && !ras_hit) begin
            err_d = 1'b1;
        end
        if (pop && ras_hit && push) begin
            ras_d[top_q] = pc_q;
        end else if (pop && ras_hit) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end else if (push) begin
            top_d          = top_inc;
            ras_d[top_inc] = pc_q;
            if (cnt_q != DEPTH_C) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == DEPTH_C);
    end

    // Stack pointer, count, flags and sticky error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Stack entries carry no reset; count decides which are meaningful.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign ras_empty = empty_q;
    assign ras_full  = full_q;
    assign ras_err   = err_q;
`else
    logic ret_unused;

    assign ret_unused = ret;
    assign take_ret   = 1'b0;
    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_err    = 1'b0;
`endif

    // Decode the strobes into this cycle's operation.
    always_comb begin
        phase = PH_IDLE;
        if (pc_en) begin
            if (!pc_ld)        phase = PH_INC;
            else if (take_ret) phase = PH_LOAD_RET;
            else if (rel)      phase = PH_LOAD_REL;
            else               phase = PH_LOAD_ABS;
        end
    end

    // Next PC per operation; link captures the pre-update PC on any linked load.
    always_comb begin
        pc_d   = pc_q;
        link_d = link_q;
        case (phase)
            PH_INC:      pc_d = pc_q + ADDR_W'(1);
            PH_LOAD_ABS: pc_d = tgt_reg;
            PH_LOAD_REL: pc_d = pc_q + disp_ext;
            PH_LOAD_RET: pc_d = ras_hit ? ras_top : tgt_reg;
            default:     pc_d = pc_q;
        endcase
        if (pc_en && pc_ld && link) begin
            link_d = pc_q;
        end
    end

    // PC and link registers; reset wins over any strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_VEC;
            link_q <= '0;
        end else begin
            pc_q   <= pc_d;
            link_q <= link_d;
        end
    end

    assign pc_out   = pc_q;
    assign link_out = link_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors for pc_unit. Expected register values after
// each strobe are hand-computed and queued; a monitor compares them one cycle
// later. Expectations that depend on the return-address stack switch on the
// PC_RAS_EN macro.
module tb_pc_unit;

  localparam int W = 35;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_en = 1'b0;
  logic        pc_ld = 1'b0;
  logic        rel = 1'b0;
  logic [15:0] tgt_reg = '0;
  logic [7:0]  disp = '0;
  logic        link = 1'b0;
  logic        ret = 1'b0;
  logic [15:0] pc_out;
  logic [15:0] link_out;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] act;
  logic [W-1:0] mon_e;
  string        mon_n;

  pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .pc_en     (pc_en),
    .pc_ld     (pc_ld),
    .rel       (rel),
    .tgt_reg   (tgt_reg),
    .disp      (disp),
    .link      (link),
    .ret       (ret),
    .pc_out    (pc_out),
    .link_out  (link_out),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  // clock
  always #5 clk = ~clk;

  assign act = {pc_out, link_out, ras_empty, ras_full, ras_err};

  // driver: apply one cycle of inputs and queue the state expected after the edge
  task automatic step(input logic rst, input logic en, input logic ld, input logic rl,
                      input logic lk, input logic rt, input logic [15:0] tgt,
                      input logic [7:0] d, input logic [15:0] e_pc, input logic [15:0] e_link,
                      input logic e_emp, input logic e_full, input logic e_err,
                      input string nm);
    @(negedge clk);
    reset   = rst;
    pc_en   = en;
    pc_ld   = ld;
    rel     = rl;
    link    = lk;
    ret     = rt;
    tgt_reg = tgt;
    disp    = d;
    exp_q.push_back({e_pc, e_link, e_emp, e_full, e_err});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor: compare after every edge that has an outstanding expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        failures++;
        $display("FAIL %s: got pc=%h link=%h emp=%b full=%b err=%b, expected pc=%h link=%h emp=%b full=%b err=%b",
                 mon_n, act[34:19], act[18:3], act[2], act[1], act[0],
                 mon_e[34:19], mon_e[18:3], mon_e[2], mon_e[1], mon_e[0]);
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
    $fatal(1, "timeout");
  end

  // stimulus
  initial begin
    // reset and increment
    step(1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 16'h0000, 1, 0, 0, "reset");
    step(0, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0001, 16'h0000, 1, 0, 0, "inc1");
    step(0, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0002, 16'h0000, 1, 0, 0, "inc2");
    step(0, 1, 0, 0, 1, 1, 16'h5555, 8'h00, 16'h0003, 16'h0000, 1, 0, 0, "inc3_ignore_link");
    step(1, 1, 1, 0, 1, 0, 16'hABCD, 8'h00, 16'h0000, 16'h0000, 1, 0, 0, "rst_midjump");
    // wrap and relative branches
    step(0, 1, 1, 0, 0, 0, 16'hFFFF, 8'h00, 16'hFFFF, 16'h0000, 1, 0, 0, "abs_ffff");
    step(0, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 16'h0000, 1, 0, 0, "inc_wrap");
    step(0, 1, 1, 0, 0, 0, 16'h0005, 8'h00, 16'h0005, 16'h0000, 1, 0, 0, "abs_5");
    step(0, 1, 1, 1, 0, 0, 16'h7777, 8'hF0, 16'hFFF5, 16'h0000, 1, 0, 0, "rel_m16");
    step(0, 1, 1, 1, 0, 0, 16'h7777, 8'h80, 16'hFF75, 16'h0000, 1, 0, 0, "rel_m128");
    step(0, 1, 1, 1, 0, 0, 16'h7777, 8'h7F, 16'hFFF4, 16'h0000, 1, 0, 0, "rel_p127");
    // call and return
    step(0, 1, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 16'h0000, 1, 0, 0, "abs_10");
    step(0, 1, 1, 0, 1, 0, 16'h1234, 8'h00, 16'h1234, 16'h0010, !RAS, 0, 0, "call");
    step(0, 1, 1, 1, 0, 1, 16'h0777, 8'h05, RAS ? 16'h0010 : 16'h1239, 16'h0010, 1, 0, 0, "return");
    // five pushes into a four-deep stack
    step(0, 1, 1, 0, 0, 0, 16'h0100, 8'h00, 16'h0100, 16'h0010, 1, 0, 0, "abs_100");
    step(0, 1, 1, 0, 1, 0, 16'h0200, 8'h00, 16'h0200, 16'h0100, !RAS, 0, 0, "push_a");
    step(0, 1, 1, 0, 1, 0, 16'h0300, 8'h00, 16'h0300, 16'h0200, !RAS, 0, 0, "push_b");
    step(0, 1, 1, 0, 1, 0, 16'h0400, 8'h00, 16'h0400, 16'h0300, !RAS, 0, 0, "push_c");
    step(0, 1, 1, 0, 1, 0, 16'h0500, 8'h00, 16'h0500, 16'h0400, !RAS, RAS, 0, "push_d_full");
    step(0, 1, 1, 0, 1, 0, 16'h0600, 8'h00, 16'h0600, 16'h0500, !RAS, RAS, 0, "push_e_over");
    // five pops: E, D, C, B, then empty fallback
    step(0, 1, 1, 0, 0, 1, 16'h0F00, 8'h00, RAS ? 16'h0500 : 16'h0F00, 16'h0500, !RAS, 0, 0, "pop_e");
    step(0, 1, 1, 0, 0, 1, 16'h0F00, 8'h00, RAS ? 16'h0400 : 16'h0F00, 16'h0500, !RAS, 0, 0, "pop_d");
    step(0, 1, 1, 0, 0, 1, 16'h0F00, 8'h00, RAS ? 16'h0300 : 16'h0F00, 16'h0500, !RAS, 0, 0, "pop_c");
    step(0, 1, 1, 0, 0, 1, 16'h0F00, 8'h00, RAS ? 16'h0200 : 16'h0F00, 16'h0500, 1, 0, 0, "pop_b");
    step(0, 1, 1, 0, 0, 1, 16'h0F00, 8'h00, 16'h0F00, 16'h0500, 1, 0, RAS, "pop_empty");
    step(0, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0F01, 16'h0500, 1, 0, RAS, "err_sticky");
    // link and ret together
    step(0, 1, 1, 0, 0, 0, 16'h0200, 8'h00, 16'h0200, 16'h0500, 1, 0, RAS, "abs_200");
    step(0, 1, 1, 0, 1, 0, 16'h0040, 8'h00, 16'h0040, 16'h0200, !RAS, 0, RAS, "push_200");
    step(0, 1, 1, 0, 1, 1, 16'h0999, 8'h00, RAS ? 16'h0200 : 16'h0999, 16'h0040, !RAS, 0, RAS, "link_ret");
    step(0, 1, 1, 0, 0, 1, 16'h0AAA, 8'h00, RAS ? 16'h0040 : 16'h0AAA, 16'h0040, 1, 0, RAS, "pop_replaced");
    step(0, 1, 1, 0, 1, 1, 16'h0BBB, 8'h00, 16'h0BBB, RAS ? 16'h0040 : 16'h0AAA, !RAS, 0, RAS, "link_ret_empty");
    // hold with every other strobe active
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, i[0], 1, 1, 16'h1111 * 16'(i + 1), 8'h33, 16'h0BBB,
           RAS ? 16'h0040 : 16'h0AAA, !RAS, 0, RAS, "hold");
    end
    step(0, 1, 1, 0, 0, 1, 16'h0CCC, 8'h00, RAS ? 16'h0040 : 16'h0CCC, RAS ? 16'h0040 : 16'h0AAA, 1, 0, RAS, "pop_after_hold");
    // reset clears the sticky error
    step(1, 1, 1, 0, 1, 1, 16'h0123, 8'h00, 16'h0000, 16'h0000, 1, 0, 0, "reset2");
    step(0, 1, 1, 0, 0, 1, 16'h0DDD, 8'h00, 16'h0DDD, 16'h0000, 1, 0, RAS, "pop_empty2");
    // drain
    @(negedge clk);
    reset = 1'b0;
    pc_en = 1'b0;
    repeat (3) @(negedge clk);
    // final report
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    if (checks == 0) begin
      failures++;
      $display("FAIL report: no comparisons were made");
    end
    if (failures == 0) begin
      $display("PASS all %0d checks", checks);
    end else begin
      $display("FAIL %0d of %0d checks", failures, checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
